water_dispense_sequencer: RTL and testbench
===========================================

Name: water_dispense_sequencer

Overview:
Front-end sequencer that drives the water_dispenser's inputs and watches its output. It debounces a raw push-button and a raw cup sensor, and generates the dispense request x and cup-present qualifier y. It then meters the valve feedback z for a fixed dose, flagging completion, aborts and valve faults. It sits between the panel I/O and the water_dispenser instance.

Parameters:
DEBOUNCE, 4, consecutive stable cycles required before a debounced input changes (>=1)
DOSE, 100, number of z-high cycles constituting one full dose (>=1)
TIMEOUT, 8, max cycles in REQ waiting for z before fault (>=1)
CNT_W, 8, width of dose_count (2^CNT_W > DOSE)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
button_raw  input  1  raw dispense push-button, asynchronous
cup_raw  input  1  raw cup-present sensor, asynchronous
z  input  1  valve-open feedback from water_dispenser
x  output  1  dispense request to water_dispenser
y  output  1  debounced cup-present to water_dispenser
busy  output  1  high in REQ or DISPENSE
done  output  1  one-cycle pulse on dose completion
fault  output  1  sticky fault flag
dose_count  output  CNT_W  z-high cycles counted in current or last dispense

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; x=0, y=0, busy=0, done=0, fault=0, dose_count=0; synchronisers and debounce counters cleared; debounced button and cup = 0.
- Input path: each raw input passes through a 2-flop synchroniser. The debounced value changes only after the synchronised value has differed from it for DEBOUNCE consecutive cycles. Any agreeing cycle resets the counter. Raw-to-debounced latency is 2+DEBOUNCE cycles.
- y is a registered copy of debounced cup, updated every cycle in all states.
- btn_rise: debounced button was 0 last cycle and is 1 this cycle.
- All outputs are registered. x=1 exactly in REQ and DISPENSE.
- FSM states: IDLE, REQ, DISPENSE, DONE, HOLD, FAULT.
- IDLE: on btn_rise with cup=1, go to REQ, clear dose_count, clear wait counter. A btn_rise with cup=0 is ignored.
- REQ: wait counter increments each cycle.
  - cup=0: go to IDLE (abort; no done, no fault).
  - Else z=1: dose_count<=1; go to DONE if DOSE==1, else DISPENSE.
  - Else wait counter reaches TIMEOUT: go to FAULT.
- DISPENSE:
  - cup=0: go to IDLE (abort; dose_count holds).
  - Else z=0: go to FAULT (valve closed early).
  - Else dose_count+1; go to DONE when the incremented value equals DOSE.
- DONE: done=1 for this single cycle; go to HOLD.
- HOLD: stay until debounced button=0, then IDLE. A button held from the previous dose never re-triggers, since a fresh btn_rise is required.
- FAULT: fault=1 while in FAULT; x=0. Exit to IDLE only when debounced button=0 and cup=0 in the same cycle. fault clears on that exit.
- Priority within a cycle: cup removal > z evaluation > timeout.
- dose_count changes only in REQ/DISPENSE. It is cleared on REQ entry and holds otherwise.
- z is ignored in IDLE, DONE, HOLD and FAULT.

Test Plan:
Use DEBOUNCE=2, DOSE=5, TIMEOUT=4.
1. Reset mid-dispense: assert rst_n=0 while in DISPENSE with dose_count=3 -> x=0, busy=0, dose_count=0, fault=0 immediately (asynchronous); after release, state is IDLE.
2. Normal dose: cup_raw=1, then button_raw=1 -> x=1 four cycles after button_raw (2 sync + 2 debounce); drive z=1 -> after 5 z-high cycles, dose_count=5, done pulses 1 cycle, x=0; holding button gives no second dose; release then press again -> new REQ with dose_count cleared to 0.
3. Bounce rejection: toggle button_raw 1/0 every cycle for 10 cycles -> debounced button never rises, x stays 0; a 1-cycle glitch on cup_raw leaves y unchanged.
4. Timeout: cup=1, press button, hold z=0 -> x high for 4 cycles, then fault=1, x=0; release button with cup still present -> fault stays 1; remove cup -> fault=0, IDLE.
5. Early valve close: z=1 for 2 cycles, then z=0 -> FAULT, dose_count=2, done never asserts.
6. Cup removed during dispense with z=1: at dose_count=3 cup_raw=0 -> after debounce, x=0, busy=0, no done and no fault, dose_count holds 3. A press with cup=0 in IDLE -> x stays 0.

Source files
------------

// File: rtl/water_dispense_sequencer.sv
// rtl/water_dispense_sequencer.sv - debounced dispense front-end and valve-feedback dose meter
module water_dispense_sequencer #(
    parameter int DEBOUNCE = 4,
    parameter int DOSE     = 100,
    parameter int TIMEOUT  = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             button_raw,
    input  logic             cup_raw,
    input  logic             z,
    output logic             x,
    output logic             y,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] dose_count
);

    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DISPENSE,
        S_DONE,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        btn_sync, cup_sync;
    logic [DB_W-1:0]   btn_cnt, cup_cnt, btn_cnt_nxt, cup_cnt_nxt;
    logic              btn_deb, cup_deb, btn_deb_nxt, cup_deb_nxt;
    logic              btn_rise;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [CNT_W-1:0]  dose_nxt;

    // Two-flop synchronisers for the asynchronous panel inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync <= 2'b00;
            cup_sync <= 2'b00;
        end else begin
            btn_sync <= {btn_sync[0], button_raw};
            cup_sync <= {cup_sync[0], cup_raw};
        end
    end

    // Debounce: flip the filtered value after DEBOUNCE consecutive disagreeing cycles.
    always_comb begin
        btn_cnt_nxt = '0;
        btn_deb_nxt = btn_deb;
        cup_cnt_nxt = '0;
        cup_deb_nxt = cup_deb;
        if (btn_sync[1] != btn_deb) begin
            if (btn_cnt == DB_W'(DEBOUNCE - 1)) begin
                btn_deb_nxt = ~btn_deb;
            end else begin
                btn_cnt_nxt = btn_cnt + DB_W'(1);
            end
        end
        if (cup_sync[1] != cup_deb) begin
            if (cup_cnt == DB_W'(DEBOUNCE - 1)) begin
                cup_deb_nxt = ~cup_deb;
            end else begin
                cup_cnt_nxt = cup_cnt + DB_W'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_cnt <= '0;
            cup_cnt <= '0;
            btn_deb <= 1'b0;
            cup_deb <= 1'b0;
        end else begin
            btn_cnt <= btn_cnt_nxt;
            cup_cnt <= cup_cnt_nxt;
            btn_deb <= btn_deb_nxt;
            cup_deb <= cup_deb_nxt;
        end
    end

    // The FSM acts on the debounced values as they update, so x follows the
    // debounced press in the same cycle rather than one cycle later.
    assign btn_rise = btn_deb_nxt & ~btn_deb;

    // Next-state, dose metering and request wait counting.
    always_comb begin
        state_nxt = state;
        dose_nxt  = dose_count;
        wait_nxt  = wait_cnt;
        case (state)
            S_IDLE: begin
                if (btn_rise && cup_deb_nxt) begin
                    state_nxt = S_REQ;
                    dose_nxt  = '0;
                    wait_nxt  = '0;
                end
            end
            S_REQ: begin
                wait_nxt = wait_cnt + WAIT_W'(1);
                if (!cup_deb_nxt) begin
                    state_nxt = S_IDLE;
                end else if (z) begin
                    dose_nxt  = CNT_W'(1);
                    state_nxt = (DOSE == 1) ? S_DONE : S_DISPENSE;
                end else if (wait_nxt == WAIT_W'(TIMEOUT)) begin
                    state_nxt = S_FAULT;
                end
            end
            S_DISPENSE: begin
                if (!cup_deb_nxt) begin
                    state_nxt = S_IDLE;
                end else if (!z) begin
                    state_nxt = S_FAULT;
                end else begin
                    dose_nxt = dose_count + CNT_W'(1);
                    if (dose_nxt == CNT_W'(DOSE)) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!btn_deb_nxt) begin
                    state_nxt = S_IDLE;
                end
            end
            S_FAULT: begin
                if (!btn_deb_nxt && !cup_deb_nxt) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            dose_count <= '0;
            wait_cnt   <= '0;
            x          <= 1'b0;
            y          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_nxt;
            dose_count <= dose_nxt;
            wait_cnt   <= wait_nxt;
            x          <= (state_nxt == S_REQ) || (state_nxt == S_DISPENSE);
            y          <= cup_deb_nxt;
            busy       <= (state_nxt == S_REQ) || (state_nxt == S_DISPENSE);
            done       <= (state_nxt == S_DONE);
            fault      <= (state_nxt == S_FAULT);
        end
    end

endmodule

// File: tb/tb_water_dispense_sequencer.sv
// tb/tb_water_dispense_sequencer.sv - randomized and directed bench with a rule-level reference model
module tb_water_dispense_sequencer;

    localparam int DB = 2;
    localparam int DS = 5;
    localparam int TO = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          button_raw = 1'b0;
    logic          cup_raw = 1'b0;
    logic          z = 1'b0;
    logic          x, y, busy, done, fault;
    logic [CW-1:0] dose_count;

    int checks = 0;
    int errors = 0;

    water_dispense_sequencer #(.DEBOUNCE(DB), .DOSE(DS), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .button_raw(button_raw), .cup_raw(cup_raw), .z(z),
        .x(x), .y(y), .busy(busy), .done(done), .fault(fault), .dose_count(dose_count)
    );

    always #5 clk = ~clk;

    // Reference model: raw sample history, window debounce and the dispense rules.
    typedef enum {M_IDLE, M_REQ, M_DISP, M_DONE, M_HOLD, M_FAULT} mode_t;
    mode_t         m_mode;
    bit            bh[DB+2];
    bit            ch[DB+2];
    bit            m_db, m_dc;
    int            m_wait;
    logic [CW-1:0] m_cnt;
    bit            m_x, m_y, m_busy, m_done, m_fault;

    task automatic model_reset();
        for (int i = 0; i < DB + 2; i++) begin
            bh[i] = 1'b0;
            ch[i] = 1'b0;
        end
        m_mode = M_IDLE; m_db = 0; m_dc = 0; m_wait = 0; m_cnt = '0;
        m_x = 0; m_y = 0; m_busy = 0; m_done = 0; m_fault = 0;
    endtask

    task automatic model_step();
        bit nb, nc, b_all, c_all, rise;
        for (int i = DB + 1; i > 0; i--) begin
            bh[i] = bh[i-1];
            ch[i] = ch[i-1];
        end
        bh[0] = button_raw;
        ch[0] = cup_raw;
        // A filtered input flips only if the last DB synchronised samples all disagree with it.
        b_all = 1; c_all = 1;
        for (int k = 0; k < DB; k++) begin
            if (bh[2+k] == m_db) b_all = 0;
            if (ch[2+k] == m_dc) c_all = 0;
        end
        nb = b_all ? ~m_db : m_db;
        nc = c_all ? ~m_dc : m_dc;
        rise = nb && !m_db;
        case (m_mode)
            M_IDLE:  if (rise && nc) begin m_mode = M_REQ; m_cnt = '0; m_wait = 0; end
            M_REQ: begin
                m_wait++;
                if (!nc) m_mode = M_IDLE;
                else if (z) begin m_cnt = 1; m_mode = (DS == 1) ? M_DONE : M_DISP; end
                else if (m_wait == TO) m_mode = M_FAULT;
            end
            M_DISP: begin
                if (!nc) m_mode = M_IDLE;
                else if (!z) m_mode = M_FAULT;
                else begin m_cnt = m_cnt + 1; if (m_cnt == DS) m_mode = M_DONE; end
            end
            M_DONE:  m_mode = M_HOLD;
            M_HOLD:  if (!nb) m_mode = M_IDLE;
            M_FAULT: if (!nb && !nc) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
        m_db = nb; m_dc = nc;
        m_x = (m_mode == M_REQ) || (m_mode == M_DISP);
        m_busy = m_x;
        m_y = nc;
        m_done = (m_mode == M_DONE);
        m_fault = (m_mode == M_FAULT);
    endtask

    // One clock: the model advances on the same edge as the DUT; returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic go_idle();
        button_raw = 0; cup_raw = 0; z = 0;
        ticks(8);
    endtask

    // Press the button and wait (bounded) for x; n reports ticks taken, 99 on expiry.
    task automatic press_wait_x(output int n);
        button_raw = 1;
        n = 0;
        while (x !== 1'b1 && n < 20) begin tick(); n++; end
        if (x !== 1'b1) n = 99;
    endtask

    task automatic test_reset();
        model_reset();
        ticks(2);
        checks += 6;
        if (x !== 0)          begin errors++; $display("FAIL reset_x: got %0b expected 0", x); end
        if (y !== 0)          begin errors++; $display("FAIL reset_y: got %0b expected 0", y); end
        if (busy !== 0)       begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        if (done !== 0)       begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        if (fault !== 0)      begin errors++; $display("FAIL reset_fault: got %0b expected 0", fault); end
        if (dose_count !== 0) begin errors++; $display("FAIL reset_dose: got %0d expected 0", dose_count); end
        rst_n = 1;
        ticks(2);
    endtask

    task automatic test_normal_dose();
        int n;
        bit saw_x;
        cup_raw = 1;
        ticks(6);
        press_wait_x(n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL dose_x_latency: got %0d cycles expected 4", n); end
        z = 1;
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        checks += 4;
        if (n != DS)          begin errors++; $display("FAIL dose_cycles: got %0d expected %0d", n, DS); end
        if (dose_count !== DS) begin errors++; $display("FAIL dose_count_full: got %0d expected %0d", dose_count, DS); end
        if (x !== 0)          begin errors++; $display("FAIL dose_x_off: got %0b expected 0", x); end
        if (busy !== 0)       begin errors++; $display("FAIL dose_busy_off: got %0b expected 0", busy); end
        z = 0;
        tick();
        checks++;
        if (done !== 0) begin errors++; $display("FAIL done_pulse_width: got %0b expected 0", done); end
        saw_x = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (x === 1'b1) saw_x = 1; end
        checks++;
        if (saw_x) begin errors++; $display("FAIL held_button_retrigger: got 1 expected 0"); end
        button_raw = 0;
        ticks(6);
        press_wait_x(n);
        checks += 2;
        if (n != 4)           begin errors++; $display("FAIL second_press_x: got %0d cycles expected 4", n); end
        if (dose_count !== 0) begin errors++; $display("FAIL second_press_clear: got %0d expected 0", dose_count); end
        z = 1;
        ticks(DS + 1);
        go_idle();
    endtask

    task automatic test_reset_mid_dispense();
        int n;
        cup_raw = 1;
        ticks(6);
        press_wait_x(n);
        z = 1;
        n = 0;
        while (dose_count !== 3 && n < 20) begin tick(); n++; end
        checks++;
        if (dose_count !== 3) begin errors++; $display("FAIL mid_reach3: got %0d expected 3", dose_count); end
        rst_n = 0;
        #1;
        checks += 4;
        if (x !== 0)          begin errors++; $display("FAIL async_rst_x: got %0b expected 0", x); end
        if (busy !== 0)       begin errors++; $display("FAIL async_rst_busy: got %0b expected 0", busy); end
        if (dose_count !== 0) begin errors++; $display("FAIL async_rst_dose: got %0d expected 0", dose_count); end
        if (fault !== 0)      begin errors++; $display("FAIL async_rst_fault: got %0b expected 0", fault); end
        model_reset();
        button_raw = 0; cup_raw = 0; z = 0;
        @(negedge clk);
        tick();
        rst_n = 1;
        ticks(2);
        checks++;
        if ({x, busy, done, fault} !== 4'b0000)
            begin errors++; $display("FAIL post_rst_idle: got %b expected 0000", {x, busy, done, fault}); end
    endtask

    task automatic test_bounce();
        bit saw_x, lost_y;
        cup_raw = 1;
        ticks(6);
        saw_x = 0;
        for (int i = 0; i < 10; i++) begin
            button_raw = ~button_raw;
            tick();
            if (x === 1'b1) saw_x = 1;
        end
        button_raw = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (x === 1'b1) saw_x = 1; end
        checks++;
        if (saw_x) begin errors++; $display("FAIL bounce_x: got 1 expected 0"); end
        cup_raw = 0;
        tick();
        cup_raw = 1;
        lost_y = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (y !== 1'b1) lost_y = 1; end
        checks++;
        if (lost_y) begin errors++; $display("FAIL cup_glitch_y: got 0 expected 1"); end
    endtask

    task automatic test_timeout();
        int n, hi;
        cup_raw = 1;
        ticks(6);
        press_wait_x(n);
        hi = 0;
        while (x === 1'b1 && hi < 20) begin hi++; tick(); end
        checks += 3;
        if (hi != TO)   begin errors++; $display("FAIL timeout_x_cycles: got %0d expected %0d", hi, TO); end
        if (fault !== 1) begin errors++; $display("FAIL timeout_fault: got %0b expected 1", fault); end
        if (x !== 0)     begin errors++; $display("FAIL timeout_x: got %0b expected 0", x); end
        button_raw = 0;
        ticks(6);
        checks++;
        if (fault !== 1) begin errors++; $display("FAIL fault_sticky: got %0b expected 1", fault); end
        cup_raw = 0;
        n = 0;
        while (fault !== 1'b0 && n < 20) begin tick(); n++; end
        checks += 2;
        if (n != DB + 2) begin errors++; $display("FAIL fault_exit_latency: got %0d expected %0d", n, DB + 2); end
        if ({x, busy} !== 2'b00) begin errors++; $display("FAIL fault_exit_idle: got %b expected 00", {x, busy}); end
    endtask

    task automatic test_early_close();
        int n;
        bit saw_done;
        cup_raw = 1;
        ticks(6);
        press_wait_x(n);
        saw_done = 0;
        z = 1;
        for (int i = 0; i < 2; i++) begin tick(); if (done === 1'b1) saw_done = 1; end
        z = 0;
        tick();
        if (done === 1'b1) saw_done = 1;
        checks += 3;
        if (fault !== 1)      begin errors++; $display("FAIL early_close_fault: got %0b expected 1", fault); end
        if (dose_count !== 2) begin errors++; $display("FAIL early_close_dose: got %0d expected 2", dose_count); end
        if (saw_done)         begin errors++; $display("FAIL early_close_done: got 1 expected 0"); end
        go_idle();
    endtask

    task automatic test_cup_abort();
        int n;
        bit saw_bad, saw_x;
        cup_raw = 1;
        ticks(6);
        press_wait_x(n);
        z = 1;
        cup_raw = 0;
        saw_bad = 0;
        for (int i = 0; i < DB + 2; i++) begin tick(); if (done === 1'b1 || fault === 1'b1) saw_bad = 1; end
        checks += 3;
        if ({x, busy} !== 2'b00) begin errors++; $display("FAIL abort_idle: got %b expected 00", {x, busy}); end
        if (dose_count !== 3)    begin errors++; $display("FAIL abort_dose_hold: got %0d expected 3", dose_count); end
        if (saw_bad)             begin errors++; $display("FAIL abort_done_fault: got 1 expected 0"); end
        z = 0; button_raw = 0;
        ticks(6);
        button_raw = 1;
        saw_x = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (x === 1'b1) saw_x = 1; end
        checks += 2;
        if (saw_x)            begin errors++; $display("FAIL no_cup_press: got 1 expected 0"); end
        if (dose_count !== 3) begin errors++; $display("FAIL no_cup_dose: got %0d expected 3", dose_count); end
        go_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0)  button_raw = ~button_raw;
            if ($urandom_range(0, 39) == 0) cup_raw = ~cup_raw;
            if ($urandom_range(0, 11) == 0) z = ~m_x;
            else z = m_x;
            tick();
            checks++;
            if ({x, y, busy, done, fault, dose_count} !== {m_x, m_y, m_busy, m_done, m_fault, m_cnt}) begin
                errors++;
                $display("FAIL random_cycle%0d: got x%0b y%0b busy%0b done%0b fault%0b cnt%0d expected x%0b y%0b busy%0b done%0b fault%0b cnt%0d",
                         i, x, y, busy, done, fault, dose_count, m_x, m_y, m_busy, m_done, m_fault, m_cnt);
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_normal_dose();
        test_reset_mid_dispense();
        test_bounce();
        go_idle();
        test_timeout();
        go_idle();
        test_early_close();
        test_cup_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
